// File: rtl/minv_mdiv_seq.sv
// Host-side sequencer for the 256-bit modular inverse/division engine: loads P/A/B, starts, unloads result.
// Optional WAIT-state timeout is compiled in when MINV_SEQ_TIMEOUT_EN is defined.
module minv_mdiv_seq #(
    parameter int WORDS          = 16,
    parameter int CNT_W          = 5,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic        cmd_mode,
    output logic        cmd_ready,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        busy,
    output logic        err,
    output logic [15:0] eng_datain,
    output logic        eng_loada,
    output logic        eng_loadb,
    output logic        eng_loadp,
    output logic        eng_outx1,
    output logic        eng_outx2,
    output logic        eng_mode,
    output logic        eng_en,
    input  logic        eng_rdy,
    input  logic        eng_flag,
    input  logic [15:0] eng_x1out,
    input  logic [15:0] eng_x2out
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOADP, S_LOADA, S_LOADB, S_START, S_GUARD, S_WAIT, S_UNLOAD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic             sel_q;
    logic             load_st;
    logic             last_word;

    assign load_st   = (state == S_LOADP) || (state == S_LOADA) || (state == S_LOADB);
    assign last_word = (cnt == CNT_W'(WORDS - 1));

    // Load/unload strobes are combinational so each word moves in the cycle its handshake completes.
    assign cmd_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign din_ready  = load_st;
    assign eng_datain = load_st ? din : 16'h0;
    assign eng_loadp  = (state == S_LOADP) && din_valid;
    assign eng_loada  = (state == S_LOADA) && din_valid;
    assign eng_loadb  = (state == S_LOADB) && din_valid;
    assign eng_en     = (state == S_START);
    assign eng_mode   = busy && mode_q;
    assign dout_valid = (state == S_UNLOAD);
    assign dout       = (state == S_UNLOAD) ? (sel_q ? eng_x2out : eng_x1out) : 16'h0;
    assign eng_outx1  = (state == S_UNLOAD) && dout_ready && !sel_q;
    assign eng_outx2  = (state == S_UNLOAD) && dout_ready && sel_q;

`ifdef MINV_SEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr;
    logic             err_q;
    assign err = err_q;
`else
    // Timer absent in this build; keep the parameter referenced for lint.
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
            sel_q  <= 1'b0;
`ifdef MINV_SEQ_TIMEOUT_EN
            tmr    <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        mode_q <= cmd_mode;
                        cnt    <= '0;
                        state  <= S_LOADP;
`ifdef MINV_SEQ_TIMEOUT_EN
                        err_q  <= 1'b0;
`endif
                    end
                end
                S_LOADP, S_LOADA, S_LOADB: begin
                    if (din_valid) begin
                        if (last_word) begin
                            cnt <= '0;
                            if (state == S_LOADP)
                                state <= S_LOADA;
                            else if (state == S_LOADA && !mode_q)
                                state <= S_LOADB;
                            else
                                state <= S_START;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_START: state <= S_GUARD;
                // One dead cycle so a ready left over from the previous operation is never sampled.
                S_GUARD: begin
                    state <= S_WAIT;
`ifdef MINV_SEQ_TIMEOUT_EN
                    tmr   <= '0;
`endif
                end
                S_WAIT: begin
                    if (eng_rdy) begin
                        sel_q <= eng_flag;
                        cnt   <= '0;
                        state <= S_UNLOAD;
                    end
`ifdef MINV_SEQ_TIMEOUT_EN
                    else if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
`endif
                end
                S_UNLOAD: begin
                    if (dout_ready) begin
                        if (last_word)
                            state <= S_IDLE;
                        else
                            cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_minv_mdiv_seq.sv
// Self-checking bench for minv_mdiv_seq: behavioural engine model plus per-cycle protocol/result checker.
module tb_minv_mdiv_seq;
    localparam int TMO = 8;
    localparam logic [255:0] P_SM2 =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_mode = 1'b0, cmd_ready;
    logic [15:0] din = 16'h0;
    logic        din_valid = 1'b0, din_ready;
    logic [15:0] dout;
    logic        dout_valid, dout_ready = 1'b0;
    logic        busy, err;
    logic [15:0] eng_datain;
    logic        eng_loada, eng_loadb, eng_loadp, eng_outx1, eng_outx2, eng_mode, eng_en;
    logic        eng_rdy = 1'b0, eng_flag;
    logic [15:0] eng_x1out, eng_x2out;

    int checks = 0;
    int errors = 0;

    minv_mdiv_seq #(.WORDS(16), .CNT_W(5), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_mode(cmd_mode), .cmd_ready(cmd_ready),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .err(err),
        .eng_datain(eng_datain), .eng_loada(eng_loada), .eng_loadb(eng_loadb),
        .eng_loadp(eng_loadp), .eng_outx1(eng_outx1), .eng_outx2(eng_outx2),
        .eng_mode(eng_mode), .eng_en(eng_en), .eng_rdy(eng_rdy), .eng_flag(eng_flag),
        .eng_x1out(eng_x1out), .eng_x2out(eng_x2out)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Plain modular arithmetic over the field; inverse by Fermat since p is prime.
    function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y, input logic [255:0] p);
        logic [511:0] t;
        t = {256'd0, x} * {256'd0, y};
        t = t % {256'd0, p};
        return t[255:0];
    endfunction

    function automatic logic [255:0] modinv(input logic [255:0] a, input logic [255:0] p);
        logic [255:0] r, base, e;
        r = 256'd1;
        base = a % p;
        e = p - 256'd2;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = mulmod(r, base, p);
            base = mulmod(base, base, p);
        end
        return r;
    endfunction

    function automatic logic [255:0] eng_result(input logic m, input logic [255:0] a,
                                                input logic [255:0] b, input logic [255:0] p);
        return m ? modinv(a, p) : mulmod(b, modinv(a, p), p);
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Engine model: shifts operands in LS word first, computes on start, shifts results out.
    logic [255:0] e_p = '0, e_a = '0, e_b = '0, x1 = '0, x2 = '0;
    logic e_busy = 1'b0, e_drop = 1'b0, e_mode = 1'b0, e_flag = 1'b0, e_nflag = 1'b0;
    logic e_fresh = 1'b0, hang = 1'b0;
    int   e_lat = 0;
    assign eng_flag  = e_flag;
    assign eng_x1out = x1[15:0];
    assign eng_x2out = x2[15:0];

    always @(posedge clk) begin
        if (eng_loadp) e_p <= {eng_datain, e_p[255:16]};
        if (eng_loada) e_a <= {eng_datain, e_a[255:16]};
        if (eng_loadb) e_b <= {eng_datain, e_b[255:16]};
        if (eng_outx1) x1 <= x1 >> 16;
        if (eng_outx2) x2 <= x2 >> 16;
        if (eng_en) begin
            e_busy  <= 1'b1;
            e_drop  <= 1'b1;
            e_fresh <= 1'b0;
            e_mode  <= eng_mode;
            e_nflag <= 1'($urandom_range(1, 0));
            e_lat   <= $urandom_range(20, 2);
        end else begin
            if (e_drop) begin
                eng_rdy <= 1'b0;
                e_drop  <= 1'b0;
            end
            if (e_busy && !hang) begin
                if (e_lat == 0) begin
                    e_busy  <= 1'b0;
                    eng_rdy <= 1'b1;
                    e_fresh <= 1'b1;
                    e_flag  <= e_nflag;
                    x1 <= e_nflag ? rnd256() : eng_result(e_mode, e_a, e_b, e_p);
                    x2 <= e_nflag ? eng_result(e_mode, e_a, e_b, e_p) : rnd256();
                end else begin
                    e_lat <= e_lat - 1;
                end
            end
        end
    end

    // Per-cycle checker: strobe legality, word routing, result words, hold under backpressure.
    logic [255:0] exp_res = '0;
    int in_idx = 0, out_idx = 0;
    int n_lp = 0, n_la = 0, n_lb = 0, n_en = 0, n_x1 = 0, n_x2 = 0;
    logic cur_mode = 1'b0, prev_hold = 1'b0;
    logic [15:0] prev_dout = 16'h0;

    initial begin
        logic [2:0] exp_ld;
        logic [15:0] w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_idx = 0; out_idx = 0; prev_hold = 1'b0;
                n_lp = 0; n_la = 0; n_lb = 0; n_en = 0; n_x1 = 0; n_x2 = 0;
            end else begin
                if (cmd_valid && cmd_ready) begin
                    in_idx = 0; out_idx = 0; cur_mode = cmd_mode;
                    n_lp = 0; n_la = 0; n_lb = 0; n_en = 0; n_x1 = 0; n_x2 = 0;
                end
                check($countones({eng_loada, eng_loadb, eng_loadp, eng_outx1, eng_outx2, eng_en}) <= 1,
                      "onehot", {eng_loada, eng_loadb, eng_loadp, eng_outx1, eng_outx2, eng_en}, 0);
                exp_ld = 3'b000;
                if (din_valid && din_ready)
                    exp_ld = (in_idx < 16) ? 3'b100 : (in_idx < 32) ? 3'b010 : 3'b001;
                check({eng_loadp, eng_loada, eng_loadb} == exp_ld, "load_strobe",
                      {eng_loadp, eng_loada, eng_loadb}, exp_ld);
                if (din_valid && din_ready) begin
                    check(eng_datain == din, "datain", eng_datain, din);
                    in_idx++;
                end
                if (busy) check(eng_mode == cur_mode, "eng_mode", eng_mode, cur_mode);
                check({eng_outx1, eng_outx2} == {dout_valid && dout_ready && !e_flag,
                                                 dout_valid && dout_ready && e_flag},
                      "out_strobe", {eng_outx1, eng_outx2}, {dout_valid && dout_ready && !e_flag,
                                                             dout_valid && dout_ready && e_flag});
                if (dout_valid) check(e_fresh, "stale_rdy", e_fresh, 1);
                if (prev_hold && dout_valid) check(dout == prev_dout, "hold", dout, prev_dout);
                if (dout_valid && dout_ready) begin
                    check(out_idx < 16, "extra_word", out_idx, 15);
                    if (out_idx < 16) begin
                        w = exp_res[out_idx*16 +: 16];
                        check(dout == w, $sformatf("dout_w%0d", out_idx), dout, w);
                    end
                    out_idx++;
                end
                prev_hold = dout_valid && !dout_ready;
                prev_dout = dout;
                n_lp += int'(eng_loadp); n_la += int'(eng_loada); n_lb += int'(eng_loadb);
                n_en += int'(eng_en); n_x1 += int'(eng_outx1); n_x2 += int'(eng_outx2);
            end
        end
    end

    task automatic do_cmd(input bit m);
        int n = 0;
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_mode = m;
        while (!ok && n < 100) begin
            @(negedge clk); ok = cmd_ready;
            @(posedge clk); #1; n++;
        end
        cmd_valid = 1'b0; cmd_mode = 1'b0;
        check(ok, "cmd_accept", ok, 1);
    endtask

    task automatic send_words(input logic [255:0] v, input bit stall, input int nw);
        int k = 0, n = 0;
        bit gap = 1'b0, took;
        while (k < nw && n < 500) begin
            if (gap) begin din_valid = 1'b0; din = 16'($urandom); end
            else begin din_valid = 1'b1; din = v[k*16 +: 16]; end
            @(negedge clk); took = din_valid && din_ready;
            @(posedge clk); #1; n++;
            if (took) k++;
            gap = stall ? !gap : 1'b0;
        end
        din_valid = 1'b0;
        check(k == nw, "din_timeout", k, nw);
    endtask

    task automatic recv(input bit stall);
        int k = 0, hold = 0, n = 0;
        dout_ready = 1'b1;
        while (k < 16 && n < 3000) begin
            @(negedge clk);
            if (dout_valid && dout_ready) k++;
            else if (dout_valid) hold++;
            @(posedge clk); #1; n++;
            dout_ready = !(stall && k == 3 && hold < 5);
        end
        dout_ready = 1'b0;
        check(k == 16, "dout_timeout", k, 16);
    endtask

    task automatic run_op(input bit m, input logic [255:0] a, input logic [255:0] b, input bit stall);
        exp_res = eng_result(m, a, b, P_SM2);
        do_cmd(m);
        check(err == 1'b0, "err_clear", err, 0);
        send_words(P_SM2, stall, 16);
        send_words(a, stall, 16);
        if (!m) send_words(b, stall, 16);
        recv(stall);
        check(n_lp == 16, "n_loadp", n_lp, 16);
        check(n_la == 16, "n_loada", n_la, 16);
        check(n_lb == (m ? 0 : 16), "n_loadb", n_lb, m ? 0 : 16);
        check(n_en == 1, "n_en", n_en, 1);
        check(n_x1 + n_x2 == 16, "n_out", n_x1 + n_x2, 16);
        check(cmd_ready == 1'b1, "idle_after", cmd_ready, 1);
    endtask

    task automatic reset_pulse();
        din_valid = 1'b1; din = 16'hA5A5;
        #1 rst = 1'b0;
        #1;
        check(busy == 1'b0, "rst_busy", busy, 0);
        check({eng_loada, eng_loadb, eng_loadp, eng_outx1, eng_outx2, eng_en} == 6'b0,
              "rst_strobes", {eng_loada, eng_loadb, eng_loadp, eng_outx1, eng_outx2, eng_en}, 0);
        @(posedge clk); #1;
        rst = 1'b1; din_valid = 1'b0;
        #1 check(cmd_ready == 1'b1, "rst_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        logic [255:0] t, a, b;
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check(cmd_ready == 1'b1, "reset_cmd_ready", cmd_ready, 1);
        check({busy, err, din_ready, dout_valid} == 4'b0, "reset_flags", {busy, err, din_ready, dout_valid}, 0);
        check({eng_loada, eng_loadb, eng_loadp, eng_outx1, eng_outx2, eng_en, eng_mode} == 7'b0,
              "reset_strobes", {eng_loada, eng_loadb, eng_loadp, eng_outx1, eng_outx2, eng_en, eng_mode}, 0);
        check({dout, eng_datain} == 32'h0, "reset_data", {dout, eng_datain}, 0);

        // Pin the field arithmetic with independently derived values.
        t = P_SM2 + 256'd1;
        check(modinv(256'd3, P_SM2) == t / 256'd3, "model_inv3", modinv(256'd3, P_SM2), t / 256'd3);
        check(mulmod(256'd3, modinv(256'd3, P_SM2), P_SM2) == 256'd1, "model_3x", 0, 1);
        check(modinv(256'd1, P_SM2) == 256'd1, "model_inv1", modinv(256'd1, P_SM2), 1);
        check(eng_result(1'b0, 256'd3, 256'd6, P_SM2) == 256'd2, "model_div",
              eng_result(1'b0, 256'd3, 256'd6, P_SM2), 2);

        @(posedge clk); #1;
        run_op(1'b1, 256'd3, 256'd0, 1'b0);
        run_op(1'b0, 256'd3, 256'd6, 1'b0);
        run_op(1'b0, rnd256() % P_SM2 | 256'd1, rnd256(), 1'b1);
        for (int i = 0; i < 6; i++) begin
            a = rnd256() % P_SM2;
            if (a == 0) a = 256'd5;
            b = rnd256();
            run_op(1'($urandom_range(1, 0)), a, b, 1'($urandom_range(1, 0)));
        end

        // Reset in the middle of loading A, then a clean inverse.
        do_cmd(1'b1);
        send_words(P_SM2, 1'b0, 16);
        send_words(256'd7, 1'b0, 7);
        reset_pulse();
        run_op(1'b1, 256'h1234_5678_9ABC, 256'd0, 1'b0);

        // Engine that never completes.
        hang = 1'b1;
        do_cmd(1'b1);
        send_words(P_SM2, 1'b0, 16);
        send_words(256'd9, 1'b0, 16);
        n = 0;
        while (!eng_en && n < 10) begin @(negedge clk); n++; end
        check(eng_en, "hang_start", eng_en, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 40);
`ifdef MINV_SEQ_TIMEOUT_EN
        check(n == TMO + 2, "tmo_cycles", n, TMO + 2);
        check(err == 1'b1, "tmo_err", err, 1);
        check(n_x1 + n_x2 == 0, "tmo_no_out", n_x1 + n_x2, 0);
        hang = 1'b0;
        @(posedge clk); #1;
`else
        check(n == 40 && busy, "wait_holds", n, 40);
        check(err == 1'b0, "err_tied", err, 0);
        hang = 1'b0;
        @(posedge clk); #1;
        reset_pulse();
`endif
        run_op(1'b0, 256'd11, 256'd22, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
